saida_write_arbiter: RTL and testbench

- Shares the 4-bit output PIO (Avalon-MM slave, `s1`) among NUM_REQ independent requesters. Each requester submits a value; the block round-robin arbitrates and issues exactly one Avalon write to the PIO data register (offset 0).
- After each write, the block holds ownership for HOLD_CYCLES so the pattern stays visible on out_port. It then acks the requester and accepts the next request.
- Sits between the user logic and the PIO slave, in place of a CPU master for that slave.

---
 rtl/saida_arb_pkg.sv | 19 +
 rtl/rr_priority_picker.sv | 29 ++
 rtl/saida_write_arbiter.sv | 133 +++++++++++++
 tb/tb_saida_write_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/saida_arb_pkg.sv
// Shared types and constants for the PIO write arbiter and its round-robin picker.
// Pure declarations: no latency, no backpressure.
package saida_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;
    localparam int         PIO_BUS_W       = 32;

    // Owner index width, never narrower than one bit.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first asserted request after last_i, wrapping modulo NUM_REQ.
// Purely combinational, zero latency; no backpressure (caller decides when to consume).
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int OWNER_W = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [OWNER_W-1:0] last_i,
    output logic               vld_o,
    output logic [OWNER_W-1:0] grant_o
);

    logic [OWNER_W-1:0] idx;

    // Scan from farthest to nearest so the nearest asserted index after last_i wins.
    always_comb begin
        vld_o   = 1'b0;
        grant_o = '0;
        idx     = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = OWNER_W'((int'(last_i) + off) % NUM_REQ);
            if (req_i[idx]) begin
                vld_o   = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/saida_write_arbiter.sv
// Round-robin owner of a 4-bit PIO: one Avalon write per grant, then HOLD_CYCLES of ownership.
// Write strobe one cycle after the request is sampled in IDLE; requests wait (not seen) while busy.
module saida_write_arbiter
    import saida_arb_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  DATA_W      = 4,
    parameter int  HOLD_CYCLES = 16,
    localparam int OWNER_W     = owner_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [OWNER_W-1:0]        owner,
    output logic [1:0]                m_address,
    output logic                      m_chipselect,
    output logic                      m_write_n,
    output logic [PIO_BUS_W-1:0]      m_writedata
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("saida_write_arbiter: NUM_REQ must be in 2..8");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("saida_write_arbiter: HOLD_CYCLES must be >= 1");
    end
    if (DATA_W > PIO_BUS_W) begin : g_bad_data_w
        $error("saida_write_arbiter: DATA_W wider than the PIO bus");
    end

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [OWNER_W-1:0]     last_q;
    logic [OWNER_W-1:0]     owner_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic                   busy_q;
    logic                   cs_q;
    logic                   write_n_q;
    logic [PIO_BUS_W-1:0]   writedata_q;

    logic                   pick_vld_d;
    logic [OWNER_W-1:0]     pick_idx_d;
    logic [DATA_W-1:0]      pick_dat_d;
    logic [NUM_REQ-1:0]     pick_oh_d;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .OWNER_W (OWNER_W)
    ) u_picker (
        .req_i   (req),
        .last_i  (last_q),
        .vld_o   (pick_vld_d),
        .grant_o (pick_idx_d)
    );

    // Constant-index mux keeps the slice select free of variable part-selects.
    always_comb begin
        pick_dat_d = '0;
        pick_oh_d  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx_d == OWNER_W'(i)) begin
                pick_dat_d   = req_data[i*DATA_W +: DATA_W];
                pick_oh_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= OWNER_W'(NUM_REQ - 1);
            owner_q     <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            writedata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        // Bus outputs are set up here so the strobe lands in the WRITE cycle.
                        state_q     <= WRITE;
                        owner_q     <= pick_idx_d;
                        last_q      <= pick_idx_d;
                        ack_q       <= pick_oh_d;
                        busy_q      <= 1'b1;
                        cs_q        <= 1'b1;
                        write_n_q   <= 1'b0;
                        writedata_q <= PIO_BUS_W'(pick_dat_d);
                    end
                end
                WRITE: begin
                    state_q   <= HOLD;
                    cnt_q     <= CNT_W'(HOLD_CYCLES - 1);
                    ack_q     <= '0;
                    cs_q      <= 1'b0;
                    write_n_q <= 1'b1;
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    ack_q     <= '0;
                    cs_q      <= 1'b0;
                    write_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign ack          = ack_q;
    assign busy         = busy_q;
    assign owner        = owner_q;
    assign m_address    = PIO_DATA_OFFSET;
    assign m_chipselect = cs_q;
    assign m_write_n    = write_n_q;
    assign m_writedata  = writedata_q;

endmodule

// File: tb/tb_saida_write_arbiter.sv
// Scoreboard bench: stimulus queues expected PIO writes, negedge monitors pop and compare.
// Instance a uses HOLD_CYCLES=16, instance b uses HOLD_CYCLES=1.
module tb_saida_write_arbiter;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  ack;
        logic [1:0]  own;
        logic [7:0]  gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  a_req = '0, b_req = '0;
    logic [15:0] a_data = '0, b_data = '0;
    logic [3:0]  a_ack, b_ack;
    logic        a_busy, b_busy;
    logic [1:0]  a_owner, b_owner;
    logic [1:0]  a_addr, b_addr;
    logic        a_cs, b_cs, a_wn, b_wn;
    logic [31:0] a_wdata, b_wdata;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   a_last = 0, b_last = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    saida_write_arbiter #(.NUM_REQ(4), .DATA_W(4), .HOLD_CYCLES(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .req(a_req), .req_data(a_data),
        .ack(a_ack), .busy(a_busy), .owner(a_owner), .m_address(a_addr),
        .m_chipselect(a_cs), .m_write_n(a_wn), .m_writedata(a_wdata)
    );

    saida_write_arbiter #(.NUM_REQ(4), .DATA_W(4), .HOLD_CYCLES(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(b_req), .req_data(b_data),
        .ack(b_ack), .busy(b_busy), .owner(b_owner), .m_address(b_addr),
        .m_chipselect(b_cs), .m_write_n(b_wn), .m_writedata(b_wdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req_v, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input logic [3:0] d, input logic [3:0] a, input logic [1:0] o, input int g);
        qa.push_back('{dat: {28'b0, d}, ack: a, own: o, gap: 8'(g)});
    endtask

    task automatic push_b(input logic [3:0] d, input logic [3:0] a, input logic [1:0] o, input int g);
        qb.push_back('{dat: {28'b0, d}, ack: a, own: o, gap: 8'(g)});
    endtask

    task automatic wait_a_idle();
        int n = 0;
        while (a_busy && n < 100) begin tick(1); n++; end
        chk("a_idle_timeout", 32'(a_busy), 32'd0);
    endtask

    task automatic wait_a_drain();
        int n = 0;
        while (qa.size() != 0 && n < 200) begin tick(1); n++; end
        chk("a_drain_timeout", 32'(qa.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (a_cs && !a_wn) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_write: got data 0x%0h ack 0x%0h, expected no write", a_wdata, a_ack);
            end else begin
                ea = qa.pop_front();
                chk("a_wdata", a_wdata, ea.dat);
                chk("a_ack", 32'(a_ack), 32'(ea.ack));
                chk("a_owner", 32'(a_owner), 32'(ea.own));
                chk("a_addr", 32'(a_addr), 32'd0);
                if (ea.gap != 0) chk("a_write_spacing", 32'(cyc - a_last), 32'(ea.gap));
            end
            a_last = cyc;
        end else if (a_ack != 4'b0) begin
            checks++; errors++;
            $display("FAIL a_stray_ack: got 0x%0h outside write, expected 0", a_ack);
        end
    end

    always @(negedge clk) begin
        if (b_cs && !b_wn) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_write: got data 0x%0h ack 0x%0h, expected no write", b_wdata, b_ack);
            end else begin
                eb = qb.pop_front();
                chk("b_wdata", b_wdata, eb.dat);
                chk("b_ack", 32'(b_ack), 32'(eb.ack));
                chk("b_owner", 32'(b_owner), 32'(eb.own));
                if (eb.gap != 0) chk("b_write_spacing", 32'(cyc - b_last), 32'(eb.gap));
            end
            b_last = cyc;
        end else if (b_ack != 4'b0) begin
            checks++; errors++;
            $display("FAIL b_stray_ack: got 0x%0h outside write, expected 0", b_ack);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick(2);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_cs", 32'(a_cs), 32'd0);
        chk("rst_wn", 32'(a_wn), 32'd1);
        chk("rst_ack", 32'(a_ack), 32'd0);
        chk("rst_owner", 32'(a_owner), 32'd0);
        chk("rst_wdata", a_wdata, 32'd0);
        chk("rst_addr", 32'(a_addr), 32'd0);
        reset_n = 1'b1;
        tick(1);

        // Single requester 1, then exactly 16 HOLD cycles
        a_req = 4'b0010; a_data = 16'h00A0;
        push_a(4'hA, 4'b0010, 2'd1, 0);
        tick(1);
        chk("t2_strobe_latency", 32'(a_cs), 32'd1);
        a_req = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            chk("t2_hold_busy", 32'(a_busy), 32'd1);
            chk("t2_hold_cs", 32'(a_cs), 32'd0);
        end
        chk("t2_hold_wdata", a_wdata, 32'h0000_000A);
        tick(1);
        chk("t2_back_idle", 32'(a_busy), 32'd0);

        // All four requesting after reset: 0,1,2,3 spaced 18 cycles
        reset_n = 1'b0; tick(1);
        reset_n = 1'b1; a_req = 4'b1111; a_data = 16'h4321;
        push_a(4'h1, 4'b0001, 2'd0, 0);
        push_a(4'h2, 4'b0010, 2'd1, 18);
        push_a(4'h3, 4'b0100, 2'd2, 18);
        push_a(4'h4, 4'b1000, 2'd3, 18);
        wait_a_drain();
        a_req = 4'b0000;
        wait_a_idle();

        // Requesters 0 and 2 held: alternate, 1 and 3 never acked
        a_req = 4'b0101; a_data = 16'hE9E6;
        push_a(4'h6, 4'b0001, 2'd0, 0);
        push_a(4'h9, 4'b0100, 2'd2, 18);
        push_a(4'h6, 4'b0001, 2'd0, 18);
        push_a(4'h9, 4'b0100, 2'd2, 18);
        wait_a_drain();
        a_req = 4'b0000;
        wait_a_idle();

        // Data changed during WRITE is ignored; a req pulse inside HOLD is never seen
        a_req = 4'b0010; a_data = 16'h0050;
        push_a(4'h5, 4'b0010, 2'd1, 0);
        tick(1);
        a_data = 16'h00F0; a_req = 4'b0000;
        tick(3);
        a_req = 4'b0100; a_data = 16'h07F0;
        tick(3);
        chk("t6_still_hold", 32'(a_busy), 32'd1);
        a_req = 4'b0000;
        wait_a_idle();
        tick(20);
        chk("t6_no_extra_write", 32'(qa.size()), 32'd0);

        // Reset mid-HOLD, then requester 0 wins
        a_req = 4'b1000; a_data = 16'h7000;
        push_a(4'h7, 4'b1000, 2'd3, 0);
        tick(1);
        a_req = 4'b0000;
        tick(5);
        reset_n = 1'b0; tick(1);
        chk("t1_busy", 32'(a_busy), 32'd0);
        chk("t1_wn", 32'(a_wn), 32'd1);
        chk("t1_cs", 32'(a_cs), 32'd0);
        chk("t1_ack", 32'(a_ack), 32'd0);
        chk("t1_owner", 32'(a_owner), 32'd0);
        reset_n = 1'b1; a_req = 4'b0001; a_data = 16'h0003;
        push_a(4'h3, 4'b0001, 2'd0, 0);
        tick(1);
        chk("t1_regrant_cs", 32'(a_cs), 32'd1);
        chk("t1_regrant_owner", 32'(a_owner), 32'd0);
        a_req = 4'b0000;
        wait_a_idle();

        // HOLD_CYCLES=1: strobe every 3 cycles, busy low one cycle between grants
        b_req = 4'b1000; b_data = 16'hC000;
        push_b(4'hC, 4'b1000, 2'd3, 0);
        push_b(4'hC, 4'b1000, 2'd3, 3);
        push_b(4'hC, 4'b1000, 2'd3, 3);
        push_b(4'hC, 4'b1000, 2'd3, 3);
        tick(1);
        for (int i = 0; i < 9; i++) begin
            chk("t5_busy_pattern", 32'(b_busy), (i % 3 != 2) ? 32'd1 : 32'd0);
            tick(1);
        end
        b_req = 4'b0000;
        tick(10);
        chk("t5_drain", 32'(qb.size()), 32'd0);
        chk("t1_t6_drain", 32'(qa.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
